// File: rtl/qchannel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qchannel_ctrl
// Brief    : Q-channel low-power handshake controller that quiesces a Wishbone
//            peripheral before accepting, or denies when it cannot drain.
// Revision : 1.0  initial release
// ============================================================================
module qchannel_ctrl #(
    parameter int NUM_BUSY    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8,
    parameter int DRAIN_TMO   = 255,
    parameter int DENY_EN     = 1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                qreqn,
    output logic                qacceptn,
    output logic                qdeny,
    output logic                qactive,
    input  logic                wb_cyc_i,
    input  logic [NUM_BUSY-1:0] busy_i,
    input  logic                wake_i,
    output logic                bus_en_o,
    output logic                periph_en_o,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DENIED  = 3'd3
    } state_t;

    localparam logic             c_DENY_EN  = (DENY_EN != 0);
    localparam logic             c_TMO_EN   = (DRAIN_TMO != 0);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(DRAIN_TMO - 1);
    localparam logic [TMO_W-1:0] c_TMO_MAX  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic             r_qacceptn;
    logic             r_qdeny;
    logic             r_bus_en;
    logic             r_periph_en;
    logic             w_qreqn_s;
    logic             w_busy_any;
    logic             w_tmo_hit;

    // Synchroniser resets to 0 so the block comes up as if a request were pending.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_qreqn_s = qreqn;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= qreqn;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_qreqn_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_busy_any = |busy_i;
    assign w_tmo_hit  = c_TMO_EN && (r_tmo == c_TMO_LAST);

    // Withdrawal beats accept so qacceptn never falls after qreqn has risen.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOPPED: if (w_qreqn_s) w_state_nxt = ST_RUN;
            ST_RUN:     if (!w_qreqn_s && !wb_cyc_i) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (w_qreqn_s)
                    w_state_nxt = ST_RUN;
                else if (!w_busy_any)
                    w_state_nxt = ST_STOPPED;
                else if (c_DENY_EN && (wb_cyc_i || w_tmo_hit))
                    w_state_nxt = ST_DENIED;
            end
            ST_DENIED:  if (w_qreqn_s) w_state_nxt = ST_RUN;
            default:    w_state_nxt = ST_STOPPED;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_STOPPED;
            r_tmo       <= '0;
            r_qacceptn  <= 1'b0;
            r_qdeny     <= 1'b0;
            r_bus_en    <= 1'b0;
            r_periph_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_qacceptn  <= (w_state_nxt != ST_STOPPED);
            r_qdeny     <= (w_state_nxt == ST_DENIED);
            r_bus_en    <= (w_state_nxt == ST_RUN);
            r_periph_en <= (w_state_nxt != ST_STOPPED);
            if (r_state != ST_DRAIN)
                r_tmo <= '0;
            else if (r_tmo != c_TMO_MAX)
                r_tmo <= r_tmo + 1'b1;
        end
    end

    assign qacceptn    = r_qacceptn;
    assign qdeny       = r_qdeny;
    assign bus_en_o    = r_bus_en;
    assign periph_en_o = r_periph_en;
    assign state_o     = r_state;
    assign qactive     = wake_i | wb_cyc_i | w_busy_any;

endmodule
`default_nettype wire

// File: tb/tb_qchannel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qchannel_ctrl
// Brief    : Directed self-checking bench for qchannel_ctrl (deny-enabled and
//            deny-disabled builds, DRAIN_TMO=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_qchannel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       qreqn, wb_cyc, busy, wake;
    logic       qacceptn, qdeny, qactive, bus_en, periph_en;
    logic [2:0] state;
    logic       q2, cyc2, busy2, wake2;
    logic       qacceptn2, qdeny2, qactive2, bus_en2, periph_en2;
    logic [2:0] state2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qchannel_ctrl #(
        .NUM_BUSY(1), .SYNC_STAGES(2), .TMO_W(8), .DRAIN_TMO(4), .DENY_EN(1)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .qreqn(qreqn), .qacceptn(qacceptn),
        .qdeny(qdeny), .qactive(qactive), .wb_cyc_i(wb_cyc), .busy_i(busy),
        .wake_i(wake), .bus_en_o(bus_en), .periph_en_o(periph_en), .state_o(state)
    );

    qchannel_ctrl #(
        .NUM_BUSY(1), .SYNC_STAGES(2), .TMO_W(8), .DRAIN_TMO(4), .DENY_EN(0)
    ) dut_nd (
        .wb_clk_i(clk), .wb_rst_i(rst), .qreqn(q2), .qacceptn(qacceptn2),
        .qdeny(qdeny2), .qactive(qactive2), .wb_cyc_i(cyc2), .busy_i(busy2),
        .wake_i(wake2), .bus_en_o(bus_en2), .periph_en_o(periph_en2), .state_o(state2)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; qreqn = 1'b1; wb_cyc = 1'b0; busy = 1'b0; wake = 1'b0;
        q2 = 1'b1; cyc2 = 1'b0; busy2 = 1'b0; wake2 = 1'b0;
        tick(3);
        checks++; if (qacceptn !== 1'b0) begin errors++; $display("FAIL t1_rst_qacceptn: got %b want 0", qacceptn); end
        checks++; if ({qdeny, bus_en, periph_en, state} !== 6'b000_000) begin errors++; $display("FAIL t1_rst_outs: got %b want 000000", {qdeny, bus_en, periph_en, state}); end
        rst = 1'b0;
        tick(2);
        checks++; if (qacceptn !== 1'b0) begin errors++; $display("FAIL t1_edge2_qacceptn: got %b want 0", qacceptn); end
        tick(1);
        checks++; if ({qacceptn, bus_en, periph_en} !== 3'b111) begin errors++; $display("FAIL t1_edge3_run: got %b want 111", {qacceptn, bus_en, periph_en}); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL t1_state_run: got %0d want 1", state); end
    endtask

    task automatic test_open_cycle;
        int bad = 0;
        wb_cyc = 1'b1; qreqn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus_en !== 1'b1 || state !== 3'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL t2_cyc_hold: got %0d bad cycles want 0", bad); end
        checks++; if (qactive !== 1'b1) begin errors++; $display("FAIL t2_qactive_cyc: got %b want 1", qactive); end
        wb_cyc = 1'b0; busy = 1'b0;
        tick(1);
        checks++; if ({state, bus_en, periph_en, qacceptn} !== {3'd2, 3'b011}) begin errors++; $display("FAIL t2_drain: got %b want 010011", {state, bus_en, periph_en, qacceptn}); end
        tick(1);
        checks++; if ({state, qacceptn, qdeny, periph_en} !== {3'd0, 3'b000}) begin errors++; $display("FAIL t2_accept: got %b want 000000", {state, qacceptn, qdeny, periph_en}); end
        qreqn = 1'b1;
        tick(3);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL t2_rerun: got %0d want 1", state); end
    endtask

    task automatic test_timeout_deny;
        busy = 1'b1; qreqn = 1'b0;
        tick(3);
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL t3_drain_entry: got %0d want 2", state); end
        tick(3);
        checks++; if ({qdeny, qacceptn, state} !== {2'b01, 3'd2}) begin errors++; $display("FAIL t3_pre_deny: got %b want 01010", {qdeny, qacceptn, state}); end
        tick(1);
        checks++; if ({qdeny, qacceptn, bus_en, periph_en, state} !== {4'b1101, 3'd3}) begin errors++; $display("FAIL t3_deny: got %b want 1101011", {qdeny, qacceptn, bus_en, periph_en, state}); end
        qreqn = 1'b1;
        tick(2);
        checks++; if (qdeny !== 1'b1) begin errors++; $display("FAIL t3_deny_hold: got %b want 1", qdeny); end
        tick(1);
        checks++; if ({qdeny, qacceptn, bus_en, state} !== {3'b011, 3'd1}) begin errors++; $display("FAIL t3_release: got %b want 011001", {qdeny, qacceptn, bus_en, state}); end
        busy = 1'b0;
    endtask

    task automatic test_cyc_deny;
        busy = 1'b1; qreqn = 1'b0; busy2 = 1'b1; q2 = 1'b0;
        tick(3);
        checks++; if ({state, state2} !== {3'd2, 3'd2}) begin errors++; $display("FAIL t4_drain: got %0d/%0d want 2/2", state, state2); end
        tick(1);
        wb_cyc = 1'b1; cyc2 = 1'b1;
        tick(1);
        checks++; if ({state, bus_en, qdeny} !== {3'd3, 2'b01}) begin errors++; $display("FAIL t4_deny: got %b want 01101", {state, bus_en, qdeny}); end
        checks++; if ({state2, qdeny2, qacceptn2} !== {3'd2, 2'b01}) begin errors++; $display("FAIL t4_nd_stay: got %b want 01001", {state2, qdeny2, qacceptn2}); end
        tick(6);
        checks++; if ({state2, qdeny2} !== {3'd2, 1'b0}) begin errors++; $display("FAIL t4_nd_no_tmo: got %b want 0100", {state2, qdeny2}); end
        busy2 = 1'b0;
        tick(1);
        checks++; if ({state2, qacceptn2, qdeny2} !== {3'd0, 2'b00}) begin errors++; $display("FAIL t4_nd_accept: got %b want 00000", {state2, qacceptn2, qdeny2}); end
        wb_cyc = 1'b0; busy = 1'b0; qreqn = 1'b1; cyc2 = 1'b0; q2 = 1'b1;
        tick(3);
        checks++; if ({state, qdeny, bus_en} !== {3'd1, 2'b01}) begin errors++; $display("FAIL t4_rerun: got %b want 00101", {state, qdeny, bus_en}); end
    endtask

    task automatic test_wake;
        qreqn = 1'b0;
        tick(4);
        checks++; if ({state, qacceptn} !== {3'd0, 1'b0}) begin errors++; $display("FAIL t5_stopped: got %b want 0000", {state, qacceptn}); end
        checks++; if (qactive !== 1'b0) begin errors++; $display("FAIL t5_qactive_idle: got %b want 0", qactive); end
        wake = 1'b1;
        #1;
        checks++; if (qactive !== 1'b1) begin errors++; $display("FAIL t5_qactive_wake: got %b want 1", qactive); end
        tick(1);
        wake = 1'b0;
        busy = 1'b1;
        #1;
        checks++; if (qactive !== 1'b1) begin errors++; $display("FAIL t5_qactive_busy: got %b want 1", qactive); end
        busy = 1'b0;
        tick(2);
        checks++; if (qacceptn !== 1'b0) begin errors++; $display("FAIL t5_hold_stopped: got %b want 0", qacceptn); end
        qreqn = 1'b1;
        tick(3);
        checks++; if (qacceptn !== 1'b1) begin errors++; $display("FAIL t5_wakeup: got %b want 1", qacceptn); end
    endtask

    task automatic test_accept_vs_tmo;
        busy = 1'b1; qreqn = 1'b0;
        tick(3);
        tick(3);
        busy = 1'b0;
        tick(1);
        checks++; if ({state, qacceptn, qdeny} !== {3'd0, 2'b00}) begin errors++; $display("FAIL t6_accept_wins: got %b want 00000", {state, qacceptn, qdeny}); end
        qreqn = 1'b1;
        tick(3);
        busy = 1'b1; qreqn = 1'b0;
        tick(7);
        checks++; if ({state, qdeny} !== {3'd3, 1'b1}) begin errors++; $display("FAIL t6_denied: got %b want 0111", {state, qdeny}); end
        rst = 1'b1;
        tick(1);
        checks++; if ({state, qdeny, qacceptn, periph_en} !== {3'd0, 3'b000}) begin errors++; $display("FAIL t6_rst_denied: got %b want 000000", {state, qdeny, qacceptn, periph_en}); end
        rst = 1'b0; busy = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_open_cycle();
        test_timeout_deny();
        test_cyc_deny();
        test_wake();
        test_accept_vs_tmo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
